// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// requester port indices, default widths and a small grant-decoding helper.
// No ports; imported by mem_arbiter and rr_pick2.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   // Arbiter FSM states. The encoding is fixed so that debug probes and
   // existing tooling see IDLE=0, ACCESS=1, WAIT=2, RESP=3.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } arb_state_e;

   // Requester port indices (also the bit position in the one-hot grant).
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;

   // Default widths.
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_MEM_LAT = 1;

   // The latency counter must count up to MEM_LAT-1 with MEM_LAT at most 7.
   localparam int LAT_CNT_W = 3;

   // One-hot grant vector for a port index.
   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage : mem_arb_pkg

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin pick. A single requester always wins;
// on a tie the port that was not granted last wins.
//
// Ports:
//   req        in   2  request vector, bit 0 = CPU, bit 1 = loader
//   last_grant in   1  port index of the previously completed transaction
//   pick       out  2  one-hot winner, 00 when nothing is requested
// -----------------------------------------------------------------------------
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] pick
);

   always_comb begin
      // NOTE: pick gets a default before the case so every path assigns it;
      // a path that leaves it unassigned would infer a latch.
      pick = 2'b00;
      case (req)
         2'b01:   pick = 2'b01;
         2'b10:   pick = 2'b10;
         2'b11:   pick = (last_grant == PORT_LDR) ? 2'b01 : 2'b10;
         default: pick = 2'b00;
      endcase
   end

endmodule : rr_pick2

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one program/data memory between the CPU instruction-fetch port (m0,
// read-only) and the loader/debug port (m1, read/write). Accesses are
// serialised through a four-state FSM (IDLE, ACCESS, WAIT, RESP); ties are
// broken round-robin so neither port starves. Read data is returned to the
// granted port together with a one-cycle acknowledge.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width (byte mask is DATA_W/8 bits)
//   MEM_LAT  memory read latency, mem_rstrb to valid mem_rdata, 1..7 cycles
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   m0_req      in   CPU read request (level)
//   m0_addr     in   CPU read address
//   m0_rdata    out  CPU read data, valid while m0_ack is high
//   m0_ack      out  one-cycle CPU completion pulse
//   m1_req      in   loader request (level)
//   m1_we       in   loader write enable (1 = write)
//   m1_addr     in   loader address
//   m1_wdata    in   loader write data
//   m1_wmask    in   loader byte-enable mask
//   m1_rdata    out  loader read data, valid while m1_ack is high
//   m1_ack      out  one-cycle loader completion pulse
//   mem_addr    out  memory address (latched request address)
//   mem_wdata   out  memory write data (latched request data)
//   mem_wmask   out  memory byte write enables, only in a write ACCESS cycle
//   mem_rstrb   out  memory read strobe, only in a read ACCESS cycle
//   mem_rdata   in   memory read data
//   grant       out  one-hot owner of the current transaction, 00 when idle
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MEM_LAT = DEF_MEM_LAT
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                m0_req,
   input  logic [ADDR_W-1:0]   m0_addr,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic                m0_ack,

   input  logic                m1_req,
   input  logic                m1_we,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wmask,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                m1_ack,

   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   output logic                mem_rstrb,
   input  logic [DATA_W-1:0]   mem_rdata,

   output logic [1:0]          grant
);

   localparam int MASK_W = DATA_W / 8;

   // Value of lat_cnt in the final WAIT cycle, when mem_rdata is valid.
   localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(MEM_LAT - 1);

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   arb_state_e           state_q;
   logic                 port_q;        // granted port index
   logic                 we_q;          // latched write enable
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [MASK_W-1:0]    wmask_q;
   logic [LAT_CNT_W-1:0] lat_cnt_q;
   logic                 last_grant_q;
   logic [DATA_W-1:0]    m0_rdata_q;
   logic [DATA_W-1:0]    m1_rdata_q;

   // -------------------------------------------------------------------------
   // Next-value helpers for the grant decision
   // -------------------------------------------------------------------------
   logic [1:0]           pick;
   logic                 port_d;
   logic [ADDR_W-1:0]    addr_d;
   logic                 we_d;
   logic [MASK_W-1:0]    wmask_d;
   logic [LAT_CNT_W-1:0] lat_cnt_d;

   rr_pick2 u_rr_pick2 (
      .req        ({m1_req, m0_req}),
      .last_grant (last_grant_q),
      .pick       (pick)
   );

   // pick[1] set means the loader won; otherwise the CPU (when pick != 0).
   assign port_d    = pick[1];
   assign addr_d    = port_d ? m1_addr : m0_addr;
   // The CPU port is read-only: its request never latches a write.
   assign we_d      = port_d & m1_we;
   assign wmask_d   = port_d ? m1_wmask : '0;
   assign lat_cnt_d = lat_cnt_q + 1'b1;

   // -------------------------------------------------------------------------
   // Arbiter FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (rst) begin
         state_q      <= ST_IDLE;
         port_q       <= PORT_CPU;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         lat_cnt_q    <= '0;
         // Pretend the loader was served last so the CPU wins the first tie.
         last_grant_q <= PORT_LDR;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick != 2'b00) begin
                  port_q  <= port_d;
                  addr_q  <= addr_d;
                  we_q    <= we_d;
                  wdata_q <= m1_wdata;
                  wmask_q <= wmask_d;
                  state_q <= ST_ACCESS;
               end
            end

            ST_ACCESS: begin
               lat_cnt_q <= '0;
               // A write is done in memory after its single ACCESS cycle,
               // even with an all-zero mask.
               state_q   <= we_q ? ST_RESP : ST_WAIT;
            end

            ST_WAIT: begin
               if (lat_cnt_q == LAT_LAST) begin
                  // Only the granted port's data register is updated.
                  if (port_q == PORT_LDR) begin
                     m1_rdata_q <= mem_rdata;
                  end else begin
                     m0_rdata_q <= mem_rdata;
                  end
                  state_q <= ST_RESP;
               end else begin
                  lat_cnt_q <= lat_cnt_d;
               end
            end

            ST_RESP: begin
               last_grant_q <= port_q;
               state_q      <= ST_IDLE;
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: decoded from registers only, never from requester inputs.
   // -------------------------------------------------------------------------
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_rstrb = (state_q == ST_ACCESS) && !we_q;
   assign mem_wmask = (state_q == ST_ACCESS && we_q) ? wmask_q : '0;

   assign grant     = (state_q == ST_IDLE) ? 2'b00 : port_onehot(port_q);

   assign m0_ack    = (state_q == ST_RESP) && (port_q == PORT_CPU);
   assign m1_ack    = (state_q == ST_RESP) && (port_q == PORT_LDR);
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiter instances share one clock and reset: index 0 with MEM_LAT=1,
// index 1 with MEM_LAT=3. Each has a small behavioural memory behind it.
// Expected cycle-by-cycle outputs are predicted from the transaction timing
// rules (ACCESS one cycle after the request is seen, ack MEM_LAT+1 cycles
// later for reads or one cycle later for writes, round-robin on ties) and a
// shadow copy of memory contents.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic clk;
   logic rst;
   logic env_load;

   logic        m0_req    [2];
   logic [31:0] m0_addr   [2];
   logic [31:0] m0_rdata  [2];
   logic        m0_ack    [2];
   logic        m1_req    [2];
   logic        m1_we     [2];
   logic [31:0] m1_addr   [2];
   logic [31:0] m1_wdata  [2];
   logic [3:0]  m1_wmask  [2];
   logic [31:0] m1_rdata  [2];
   logic        m1_ack    [2];
   logic [31:0] mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [3:0]  mem_wmask [2];
   logic        mem_rstrb [2];
   logic [31:0] mem_rdata [2];
   logic [1:0]  grant     [2];

   // Memory contents behind each DUT, and the reference copy.
   logic [31:0] env_mem [2][64];
   logic [31:0] ref_mem [2][64];
   logic [31:0] pipe    [2][3];

   // Reference model state.
   int          ref_last  [2];
   logic [31:0] exp_rd    [2][2];
   logic [31:0] exp_maddr [2];

   int vectors;
   int miscompares;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_arbiter #(
         .ADDR_W  (32),
         .DATA_W  (32),
         .MEM_LAT ((g == 0) ? 1 : 3)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .m0_req    (m0_req[g]),
         .m0_addr   (m0_addr[g]),
         .m0_rdata  (m0_rdata[g]),
         .m0_ack    (m0_ack[g]),
         .m1_req    (m1_req[g]),
         .m1_we     (m1_we[g]),
         .m1_addr   (m1_addr[g]),
         .m1_wdata  (m1_wdata[g]),
         .m1_wmask  (m1_wmask[g]),
         .m1_rdata  (m1_rdata[g]),
         .m1_ack    (m1_ack[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_wmask (mem_wmask[g]),
         .mem_rstrb (mem_rstrb[g]),
         .mem_rdata (mem_rdata[g]),
         .grant     (grant[g])
      );
   end

   // Behavioural memory: read data appears MEM_LAT cycles after the strobe
   // cycle; at other times the read bus carries junk.
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (mem_rstrb[g]) pipe[g][0] <= env_mem[g][mem_addr[g][7:2]];
         else              pipe[g][0] <= $urandom;
         pipe[g][1] <= pipe[g][0];
         pipe[g][2] <= pipe[g][1];
         for (int b = 0; b < 4; b++) begin
            if (mem_wmask[g][b]) env_mem[g][mem_addr[g][7:2]][b*8 +: 8] <= mem_wdata[g][b*8 +: 8];
         end
      end
      if (env_load) env_mem <= ref_mem;
   end
   assign mem_rdata[0] = pipe[0][0];
   assign mem_rdata[1] = pipe[1][2];

   function automatic int lat_of(input int u);
      return (u == 0) ? 1 : 3;
   endfunction

   task automatic reset_model();
      for (int u = 0; u < 2; u++) begin
         ref_last[u]  = 1;
         exp_rd[u][0] = '0;
         exp_rd[u][1] = '0;
         exp_maddr[u] = '0;
      end
   endtask

   task automatic load_env();
      env_load = 1'b1;
      @(posedge clk);
      @(negedge clk);
      env_load = 1'b0;
   endtask

   // Issue a batch of at most one request per port on instance u, starting
   // while it is idle, and compare every output every cycle until the batch
   // has completed and the arbiter is back in IDLE.
   task automatic run_batch(input int u, input bit r0, input logic [31:0] a0,
                            input bit r1, input bit we1, input logic [31:0] a1,
                            input logic [31:0] wd1, input logic [3:0] wm1);
      int          n;
      int          port [2];
      bit          wr   [2];
      int          s    [2];
      int          e    [2];
      logic [31:0] ad   [2];
      logic [31:0] rd   [2];
      logic [1:0]  eg;
      logic        ea0, ea1, estr;
      logic [3:0]  ewm;
      logic [104:0] obs, expv;
      int          idx;

      n = 0;
      if (r0 && r1) begin
         port[0] = (ref_last[u] == 1) ? 0 : 1;
         port[1] = 1 - port[0];
         n = 2;
      end else if (r0) begin
         port[0] = 0;
         n = 1;
      end else if (r1) begin
         port[0] = 1;
         n = 1;
      end

      for (int i = 0; i < n; i++) begin
         wr[i] = (port[i] == 1) && we1;
         ad[i] = (port[i] == 1) ? a1 : a0;
         s[i]  = (i == 0) ? 1 : e[i-1] + 2;
         e[i]  = s[i] + (wr[i] ? 1 : 1 + lat_of(u));
         idx   = int'(ad[i][7:2]);
         if (wr[i]) begin
            for (int b = 0; b < 4; b++)
               if (wm1[b]) ref_mem[u][idx][b*8 +: 8] = wd1[b*8 +: 8];
            rd[i] = '0;
         end else begin
            rd[i] = ref_mem[u][idx];
         end
      end

      m0_req[u] = r0;
      m0_addr[u] = a0;
      if (r1) begin
         m1_req[u]   = 1'b1;
         m1_we[u]    = we1;
         m1_addr[u]  = a1;
         m1_wdata[u] = wd1;
         m1_wmask[u] = wm1;
      end

      for (int k = 1; k <= e[n-1] + 1; k++) begin
         @(posedge clk);
         @(negedge clk);
         eg = 2'b00; ea0 = 1'b0; ea1 = 1'b0; estr = 1'b0; ewm = 4'h0;
         for (int i = 0; i < n; i++) begin
            if (k >= s[i] && k <= e[i]) eg = (port[i] == 1) ? 2'b10 : 2'b01;
            if (k == s[i]) begin
               exp_maddr[u] = ad[i];
               if (wr[i]) ewm = wm1;
               else       estr = 1'b1;
               if (wr[i]) begin
                  vectors++;
                  if (mem_wdata[u] !== wd1) begin
                     miscompares++;
                     $display("FAIL wdata u%0d k%0d: got %h expected %h", u, k, mem_wdata[u], wd1);
                  end
               end
            end
            if (k == e[i]) begin
               if (port[i] == 0) ea0 = 1'b1;
               else              ea1 = 1'b1;
               if (!wr[i]) exp_rd[u][port[i]] = rd[i];
               ref_last[u] = port[i];
            end
         end
         obs  = {grant[u], m0_ack[u], m1_ack[u], mem_rstrb[u], mem_wmask[u],
                 m0_rdata[u], m1_rdata[u], mem_addr[u]};
         expv = {eg, ea0, ea1, estr, ewm, exp_rd[u][0], exp_rd[u][1], exp_maddr[u]};
         vectors++;
         if (obs !== expv) begin
            miscompares++;
            $display("FAIL cycle u%0d k%0d {grant,ack0,ack1,rstrb,wmask,rdata0,rdata1,addr}: got %h expected %h",
                     u, k, obs, expv);
         end
         if (ea0) m0_req[u] = 1'b0;
         if (ea1) m1_req[u] = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [104:0] obs;
      repeat (2) @(posedge clk);
      @(negedge clk);
      env_load = 1'b0;
      for (int u = 0; u < 2; u++) begin
         obs = {grant[u], m0_ack[u], m1_ack[u], mem_rstrb[u], mem_wmask[u],
                m0_rdata[u], m1_rdata[u], mem_addr[u]};
         vectors++;
         if (obs !== '0 || mem_wdata[u] !== '0) begin
            miscompares++;
            $display("FAIL reset u%0d: got %h/%h expected all zero", u, obs, mem_wdata[u]);
         end
      end
      rst = 1'b0;
      reset_model();
   endtask

   task automatic test_single_read();
      ref_mem[0][4] = 32'h0050_0093;
      load_env();
      run_batch(0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      vectors++;
      if (m0_rdata[0] !== 32'h0050_0093) begin
         miscompares++;
         $display("FAIL single_read: got %h expected 00500093", m0_rdata[0]);
      end
   endtask

   task automatic test_write_then_read();
      run_batch(0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF);
      run_batch(0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      vectors++;
      if (m0_rdata[0] !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL write_then_read: got %h expected deadbeef", m0_rdata[0]);
      end
   endtask

   task automatic test_zero_mask();
      run_batch(0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0);
      run_batch(0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      vectors++;
      if (m0_rdata[0] !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL zero_mask: got %h expected deadbeef", m0_rdata[0]);
      end
   endtask

   task automatic test_contention();
      for (int t = 0; t < 2; t++)
         run_batch(0, 1'b1, {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                   1'b1, 1'b0, {24'h0, 6'($urandom_range(0, 63)), 2'b00}, 32'h0, 4'h0);
   endtask

   task automatic test_lat3();
      run_batch(1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      run_batch(1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h30, 32'h1234_5678, 4'h3);
      run_batch(1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
      run_batch(1, 1'b1, 32'h30, 1'b1, 1'b1, 32'h30, 32'hA5A5_A5A5, 4'hC);
   endtask

   task automatic test_random();
      bit r0, r1;
      for (int u = 0; u < 2; u++) begin
         for (int t = 0; t < 20; t++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            run_batch(u, r0, {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                      r1, 1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                      $urandom, 4'($urandom));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [104:0] obs;
      m0_req[1]  = 1'b1;
      m0_addr[1] = 32'h40;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      m0_req[1] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         for (int u = 0; u < 2; u++) begin
            obs = {grant[u], m0_ack[u], m1_ack[u], mem_rstrb[u], mem_wmask[u],
                   m0_rdata[u], m1_rdata[u], mem_addr[u]};
            vectors++;
            if (obs !== '0) begin
               miscompares++;
               $display("FAIL reset_mid u%0d k%0d: got %h expected all zero", u, k, obs);
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      reset_model();
      run_batch(1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      env_load    = 1'b1;
      for (int u = 0; u < 2; u++) begin
         m0_req[u] = 1'b0; m0_addr[u] = '0;
         m1_req[u] = 1'b0; m1_we[u] = 1'b0; m1_addr[u] = '0;
         m1_wdata[u] = '0; m1_wmask[u] = '0;
         for (int i = 0; i < 64; i++) ref_mem[u][i] = $urandom;
      end

      test_reset();
      test_single_read();
      test_write_then_read();
      test_zero_mask();
      test_contention();
      test_lat3();
      test_random();
      test_reset_mid();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_mem_arbiter
